menu_nav: RTL and testbench

MENU_NAV -- requirements
Module: menu_nav

---
 rtl/menu_pkg.sv | 14 +
 rtl/menu_idle_timer.sv | 41 ++++
 rtl/menu_nav.sv | 140 ++++++++++++++
 tb/tb_menu_nav.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/menu_pkg.sv
// menu_pkg: constants shared by the menu navigator and the VGA menu renderer.
//   menu_state_e : navigator state encoding, also shown on the debug LEDs
//   MENU_N_ITEMS : default number of menu entries; the last entry is exit
package menu_pkg;

    typedef enum logic [1:0] {
        ST_BROWSE = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_LOCKED = 2'd2
    } menu_state_e;

    localparam int MENU_N_ITEMS = 3;

endpackage

// File: rtl/menu_idle_timer.sv
// menu_idle_timer: counts enabled cycles and pulses expire on the terminal count.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clear    : zero the count this cycle (also suppresses expire)
//   enable   : count this cycle
//   expire   : combinational, high on the cycle the count sits at TIMEOUT_CYC-1
// The count restarts from zero on the edge that ends an expire cycle.
module menu_idle_timer #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A clear arriving on the terminal cycle wins: no homing that cycle.
    assign expire = enable && !clear && (cnt_q == TERM);

    always_comb begin
        cnt_d = cnt_q;
        if (clear || expire)
            cnt_d = '0;
        else if (enable)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/menu_nav.sv
// menu_nav: game menu navigator (BROWSE / ACTIVE / LOCKED).
// Ports:
//   sys_clk            : clock, rising edge
//   sys_rst_n          : synchronous reset, active HIGH despite the name
//   btn_up/down/sel    : one-cycle debounced button pulses
//   game_done          : one-cycle pulse from the running game
//   cursor             : highlighted entry
//   active, active_idx : game running and which entry (idx 0 when idle)
//   locked             : exit entry taken; only reset leaves
//   enter_pulse        : one cycle on BROWSE->ACTIVE/LOCKED
//   leave_pulse        : one cycle on ACTIVE->BROWSE
//   state_dbg          : state encoding for LEDs
// Optional: define MENU_NAV_IDLE_HOME_EN to home the cursor to entry 0 after
// TIMEOUT_CYC idle browse cycles. Without it no idle counter exists.
module menu_nav
    import menu_pkg::*;
#(
    parameter int N_ITEMS     = MENU_N_ITEMS,
    parameter int IDX_W       = $clog2(N_ITEMS),
    parameter int TIMEOUT_CYC = 1_000_000_000
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_sel,
    input  logic             game_done,
    output logic [IDX_W-1:0] cursor,
    output logic             active,
    output logic [IDX_W-1:0] active_idx,
    output logic             locked,
    output logic             enter_pulse,
    output logic             leave_pulse,
    output logic [1:0]       state_dbg
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_ITEMS - 1);

    if (N_ITEMS < 2 || TIMEOUT_CYC < 2) begin : g_bad_cfg
        $error("menu_nav: N_ITEMS and TIMEOUT_CYC must both be at least 2");
    end

    menu_state_e      state_q, state_d;
    logic [IDX_W-1:0] cursor_q, cursor_d;
    logic [IDX_W-1:0] active_idx_q, active_idx_d;
    logic             active_q, active_d;
    logic             locked_q, locked_d;
    logic             enter_q, enter_d;
    logic             leave_q, leave_d;
    logic             idle_expire;

`ifdef MENU_NAV_IDLE_HOME_EN
    // Idle browse cycles: any button press or being outside BROWSE restarts it.
    menu_idle_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_idle (
        .clk    (sys_clk),
        .rst    (sys_rst_n),
        .clear  (btn_up || btn_down || btn_sel || (state_q != ST_BROWSE)),
        .enable (state_q == ST_BROWSE),
        .expire (idle_expire)
    );
`else
    assign idle_expire = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        cursor_d     = cursor_q;
        active_d     = active_q;
        active_idx_d = active_idx_q;
        locked_d     = locked_q;
        enter_d      = 1'b0;
        leave_d      = 1'b0;

        unique case (state_q)
            ST_BROWSE: begin
                // down > up > sel; lower-priority simultaneous pulses dropped
                if (btn_down) begin
                    cursor_d = (cursor_q == LAST) ? '0 : cursor_q + 1'b1;
                end else if (btn_up) begin
                    cursor_d = (cursor_q == '0) ? LAST : cursor_q - 1'b1;
                end else if (btn_sel) begin
                    enter_d = 1'b1;
                    if (cursor_q == LAST) begin
                        state_d  = ST_LOCKED;
                        locked_d = 1'b1;
                    end else begin
                        state_d      = ST_ACTIVE;
                        active_d     = 1'b1;
                        active_idx_d = cursor_q;
                    end
                end else if (idle_expire) begin
                    cursor_d = '0;
                end
            end
            ST_ACTIVE: begin
                // Cursor stays on the entry being played so it is still
                // highlighted when the game returns.
                if (game_done) begin
                    state_d      = ST_BROWSE;
                    active_d     = 1'b0;
                    active_idx_d = '0;
                    leave_d      = 1'b1;
                end
            end
            ST_LOCKED: ;
            default: state_d = ST_BROWSE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst_n) begin
            state_q      <= ST_BROWSE;
            cursor_q     <= '0;
            active_q     <= 1'b0;
            active_idx_q <= '0;
            locked_q     <= 1'b0;
            enter_q      <= 1'b0;
            leave_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cursor_q     <= cursor_d;
            active_q     <= active_d;
            active_idx_q <= active_idx_d;
            locked_q     <= locked_d;
            enter_q      <= enter_d;
            leave_q      <= leave_d;
        end
    end

    assign cursor      = cursor_q;
    assign active      = active_q;
    assign active_idx  = active_idx_q;
    assign locked      = locked_q;
    assign enter_pulse = enter_q;
    assign leave_pulse = leave_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_menu_nav.sv
// tb_menu_nav: directed scoreboard bench for menu_nav (N_ITEMS=3).
// Stimulus pushes the hand-computed post-edge output vector; the monitor
// pops and compares one entry after every rising edge.
module tb_menu_nav;

    typedef struct packed {
        logic [1:0] cursor;
        logic       active;
        logic [1:0] idx;
        logic       locked;
        logic       enter;
        logic       leave;
        logic [1:0] st;
    } exp_t;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b1;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_sel = 1'b0, game_done = 1'b0;
    logic [1:0] cursor, active_idx, state_dbg;
    logic       active, locked, enter_pulse, leave_pulse;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    menu_nav #(
        .N_ITEMS     (3),
        .IDX_W       (2),
        .TIMEOUT_CYC (16)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .btn_sel     (btn_sel),
        .game_done   (game_done),
        .cursor      (cursor),
        .active      (active),
        .active_idx  (active_idx),
        .locked      (locked),
        .enter_pulse (enter_pulse),
        .leave_pulse (leave_pulse),
        .state_dbg   (state_dbg)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic exp_t e(input logic [1:0] cur, input logic act, input logic [1:0] idx,
                               input logic lck, input logic ent, input logic lv, input logic [1:0] st);
        exp_t r;
        r.cursor = cur; r.active = act; r.idx = idx; r.locked = lck;
        r.enter = ent;  r.leave = lv;   r.st = st;
        return r;
    endfunction

    // One cycle of stimulus: {rst, down, up, sel, done} and the expected outputs after the edge.
    task automatic step(input logic [4:0] in, input exp_t x, input string nm);
        @(negedge sys_clk);
        {sys_rst_n, btn_down, btn_up, btn_sel, game_done} = in;
        exp_q.push_back(x);
        name_q.push_back(nm);
    endtask

    always begin
        @(posedge sys_clk);
        #1;
        if (exp_q.size() != 0) begin
            exp_t x, got;
            string nm;
            x  = exp_q.pop_front();
            nm = name_q.pop_front();
            got = {cursor, active, active_idx, locked, enter_pulse, leave_pulse, state_dbg};
            checks++;
            if (got !== x) begin
                errors++;
                $display("FAIL %s: got cur=%0d act=%0b idx=%0d lck=%0b ent=%0b lv=%0b st=%0d, want cur=%0d act=%0b idx=%0d lck=%0b ent=%0b lv=%0b st=%0d",
                         nm, got.cursor, got.active, got.idx, got.locked, got.enter, got.leave, got.st,
                         x.cursor, x.active, x.idx, x.locked, x.enter, x.leave, x.st);
            end
        end
    end

    localparam logic [4:0] RST = 5'b10000, DN = 5'b01000, UP = 5'b00100,
                           SEL = 5'b00010, GD = 5'b00001, NOP = 5'b00000;

    initial begin
        int budget;
        repeat (2) @(posedge sys_clk);

        step(RST, e(0,0,0,0,0,0,0), "reset");
        // cursor down with wrap
        step(DN,  e(1,0,0,0,0,0,0), "down1");
        step(DN,  e(2,0,0,0,0,0,0), "down2");
        step(DN,  e(0,0,0,0,0,0,0), "down_wrap");
        step(NOP, e(0,0,0,0,0,0,0), "idle_hold");
        // priority
        step(DN|UP|SEL, e(1,0,0,0,0,0,0), "all_three");
        step(UP|SEL,    e(0,0,0,0,0,0,0), "up_over_sel");
        // enter and leave a game on entry 1
        step(DN,  e(1,0,0,0,0,0,0), "to_1");
        step(SEL, e(1,1,1,0,1,0,1), "enter_1");
        step(NOP, e(1,1,1,0,0,0,1), "enter_drop");
        step(DN,  e(1,1,1,0,0,0,1), "active_ign_dn");
        step(UP|SEL, e(1,1,1,0,0,0,1), "active_ign_up");
        step(GD,  e(1,0,0,0,0,1,0), "leave_1");
        step(NOP, e(1,0,0,0,0,0,0), "leave_drop");
        step(GD,  e(1,0,0,0,0,0,0), "done_in_browse");
        // reset beats game_done while active on entry 0
        step(UP,  e(0,0,0,0,0,0,0), "to_0");
        step(SEL, e(0,1,0,0,1,0,1), "enter_0");
        step(RST|GD, e(0,0,0,0,0,0,0), "rst_over_done");
        // exit entry locks
        step(UP,  e(2,0,0,0,0,0,0), "up_wrap");
        step(SEL, e(2,0,0,1,1,0,2), "lock");
        step(NOP, e(2,0,0,1,0,0,2), "lock_drop");
        step(DN,  e(2,0,0,1,0,0,2), "lock_ign_dn");
        step(GD,  e(2,0,0,1,0,0,2), "lock_ign_done");
        step(SEL, e(2,0,0,1,0,0,2), "lock_ign_sel");
        step(RST|DN, e(0,0,0,0,0,0,0), "rst_from_lock");

        step(UP,  e(2,0,0,0,0,0,0), "idle_setup");
`ifdef MENU_NAV_IDLE_HOME_EN
        for (int i = 0; i < 15; i++) step(NOP, e(2,0,0,0,0,0,0), "idle_wait");
        step(NOP, e(0,0,0,0,0,0,0), "idle_home");
        step(UP,  e(2,0,0,0,0,0,0), "idle_setup2");
        for (int i = 0; i < 15; i++) step(NOP, e(2,0,0,0,0,0,0), "idle_wait2");
        step(UP,  e(1,0,0,0,0,0,0), "btn_beats_home");
        for (int i = 0; i < 15; i++) step(NOP, e(1,0,0,0,0,0,0), "idle_cleared");
        step(NOP, e(0,0,0,0,0,0,0), "idle_home2");
`else
        for (int i = 0; i < 20; i++) step(NOP, e(2,0,0,0,0,0,0), "no_idle_home");
`endif

        @(negedge sys_clk);
        {sys_rst_n, btn_down, btn_up, btn_sel, game_done} = NOP;
        budget = 0;
        while (exp_q.size() != 0 && budget < 100) begin
            @(posedge sys_clk);
            budget++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
